ascensor_scan_ctrl: RTL and testbench

Parametrised elevator car controller for NUM_FLOORS floors. It replaces the single-destination controller with a pending-request bitmap and SCAN (elevator-algorithm) servicing. It also adds configurable travel and door timing, door re-open, and an arrival strobe. It sits between the hall/cab button encoder (which produces one-cycle request pulses) and the floor display/door actuator logic.

---
 rtl/ascensor_scan_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_ascensor_scan_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascensor_scan_ctrl.sv
// SCAN elevator car controller: pending-request bitmap, timed travel/doors, door re-open, arrival strobe.
// Optional PARADA_EMERGENCIA_EN adds a 'parada' input that freezes timers and blocks leaving IDLE.
module ascensor_scan_ctrl #(
    parameter int NUM_FLOORS   = 4,
    parameter int FLOOR_W      = 2,
    parameter int TRAVEL_TICKS = 50000000,
    parameter int DOOR_TICKS   = 100000000,
    parameter int CTR_W        = 27,
    parameter int RESET_FLOOR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef PARADA_EMERGENCIA_EN
    input  logic                  parada,
`endif
    input  logic [NUM_FLOORS-1:0] req_set,
    output logic [FLOOR_W-1:0]    piso,
    output logic [1:0]            direccion,
    output logic                  puertas_abiertas,
    output logic                  ocupado,
    output logic [NUM_FLOORS-1:0] pendientes,
    output logic                  llegada
);

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOORS} state_t;

    state_t                r_state;
    logic [FLOOR_W-1:0]    r_piso;
    logic [NUM_FLOORS-1:0] r_pend;
    logic [CTR_W-1:0]      r_timer;
    logic                  r_dir_mem;
    logic [1:0]            r_dir;
    logic                  r_puertas;
    logic                  r_ocupado;
    logic                  r_llegada;

    logic                  w_park;
    logic                  w_here, w_up, w_dn, w_idle_up;
    logic                  w_s_here, w_s_up, w_s_dn, w_s_ahead, w_s_behind;
    logic                  w_travel_end, w_door_end, w_reopen, w_enter_doors;
    logic [FLOOR_W-1:0]    w_step_piso, w_door_floor;
    logic [NUM_FLOORS-1:0] w_set, w_clr;

`ifdef PARADA_EMERGENCIA_EN
    assign w_park = parada;
`else
    assign w_park = 1'b0;
`endif

    function automatic logic f_bit(input logic [NUM_FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (int'(f) == i) r = p[i];
        return r;
    endfunction

    function automatic logic f_above(input logic [NUM_FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (i > int'(f)) r = r | p[i];
        return r;
    endfunction

    function automatic logic f_below(input logic [NUM_FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (i < int'(f)) r = r | p[i];
        return r;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] f_onehot(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (int'(f) == i) r[i] = 1'b1;
        return r;
    endfunction

    // dir_mem always equals the travel direction while in MOVE, so it selects the next floor.
    assign w_step_piso  = r_dir_mem ? r_piso + 1'b1 : r_piso - 1'b1;
    assign w_here       = f_bit(r_pend, r_piso);
    assign w_up         = f_above(r_pend, r_piso);
    assign w_dn         = f_below(r_pend, r_piso);
    assign w_idle_up    = (w_up && w_dn) ? r_dir_mem : w_up;
    assign w_s_here     = f_bit(r_pend, w_step_piso);
    assign w_s_up       = f_above(r_pend, w_step_piso);
    assign w_s_dn       = f_below(r_pend, w_step_piso);
    assign w_s_ahead    = r_dir_mem ? w_s_up : w_s_dn;
    assign w_s_behind   = r_dir_mem ? w_s_dn : w_s_up;
    assign w_travel_end = (r_timer == CTR_W'(TRAVEL_TICKS - 1));
    assign w_door_end   = (r_timer == CTR_W'(DOOR_TICKS - 1));
    assign w_reopen     = (r_state == S_DOORS) && f_bit(req_set, r_piso);

    always_comb begin
        w_set         = req_set;
        w_enter_doors = 1'b0;
        w_door_floor  = r_piso;
        case (r_state)
            S_IDLE:  w_enter_doors = !w_park && w_here;
            S_MOVE: begin
                w_enter_doors = !w_park && w_travel_end && w_s_here;
                w_door_floor  = w_step_piso;
            end
            S_DOORS: begin
                w_set         = req_set & ~f_onehot(r_piso);
                w_enter_doors = !w_park && !w_reopen && w_door_end && w_here;
            end
            default: w_enter_doors = 1'b0;
        endcase
        // Clearing after the OR makes the stop absorb a same-cycle request for its own floor.
        w_clr = w_enter_doors ? f_onehot(w_door_floor) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_piso    <= FLOOR_W'(RESET_FLOOR);
            r_pend    <= '0;
            r_timer   <= '0;
            r_dir_mem <= 1'b1;
            r_dir     <= 2'b00;
            r_puertas <= 1'b0;
            r_ocupado <= 1'b0;
            r_llegada <= 1'b0;
        end else begin
            r_pend    <= (r_pend | w_set) & ~w_clr;
            r_llegada <= w_enter_doors;
            case (r_state)
                S_IDLE: if (!w_park) begin
                    if (w_here) begin
                        r_state   <= S_DOORS;
                        r_timer   <= '0;
                        r_puertas <= 1'b1;
                        r_ocupado <= 1'b1;
                        r_dir     <= 2'b00;
                    end else if (w_up || w_dn) begin
                        r_state   <= S_MOVE;
                        r_timer   <= '0;
                        r_dir_mem <= w_idle_up;
                        r_dir     <= w_idle_up ? 2'b01 : 2'b10;
                        r_ocupado <= 1'b1;
                    end
                end
                S_MOVE: if (!w_park) begin
                    if (w_travel_end) begin
                        r_piso  <= w_step_piso;
                        r_timer <= '0;
                        if (w_s_here) begin
                            r_state   <= S_DOORS;
                            r_puertas <= 1'b1;
                            r_dir     <= 2'b00;
                        end else if (!w_s_ahead) begin
                            if (w_s_behind) begin
                                r_dir_mem <= ~r_dir_mem;
                                r_dir     <= r_dir_mem ? 2'b10 : 2'b01;
                            end else begin
                                r_state   <= S_IDLE;
                                r_ocupado <= 1'b0;
                                r_dir     <= 2'b00;
                            end
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_DOORS: if (w_reopen) begin
                    r_timer <= '0;
                end else if (!w_park) begin
                    if (w_door_end) begin
                        r_timer <= '0;
                        if (w_here) begin
                            r_puertas <= 1'b1;
                        end else if (w_up || w_dn) begin
                            r_state   <= S_MOVE;
                            r_puertas <= 1'b0;
                            r_dir_mem <= w_idle_up;
                            r_dir     <= w_idle_up ? 2'b01 : 2'b10;
                        end else begin
                            r_state   <= S_IDLE;
                            r_puertas <= 1'b0;
                            r_ocupado <= 1'b0;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign piso             = r_piso;
    assign direccion        = r_dir;
    assign puertas_abiertas = r_puertas;
    assign ocupado          = r_ocupado;
    assign pendientes       = r_pend;
    assign llegada          = r_llegada;

endmodule

// File: tb/tb_ascensor_scan_ctrl.sv
// Scoreboard bench for ascensor_scan_ctrl: expected floor steps, arrivals and door-open lengths
// are queued by the stimulus and consumed by an independent monitor.
module tb_ascensor_scan_ctrl;
    localparam int TT = 4;
    localparam int DT = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req_set = 4'b0000;
    logic [1:0] piso;
    logic [1:0] direccion;
    logic       puertas_abiertas;
    logic       ocupado;
    logic [3:0] pendientes;
    logic       llegada;

    int checks = 0;
    int failures = 0;
    int step_q[$];
    int arr_q[$];
    int dur_q[$];

    always #5 clk = ~clk;

    ascensor_scan_ctrl #(
        .NUM_FLOORS(4), .FLOOR_W(2), .TRAVEL_TICKS(TT), .DOOR_TICKS(DT), .CTR_W(8), .RESET_FLOOR(0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef PARADA_EMERGENCIA_EN
        .parada(1'b0),
`endif
        .req_set(req_set),
        .piso(piso),
        .direccion(direccion),
        .puertas_abiertas(puertas_abiertas),
        .ocupado(ocupado),
        .pendientes(pendientes),
        .llegada(llegada)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tfail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Monitor: pops expectations whenever the DUT steps a floor, strobes llegada or closes doors.
    initial begin
        int prev_piso;
        int mv_cnt;
        int door_cnt;
        int e;
        prev_piso = 0;
        mv_cnt = 0;
        door_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_piso = int'(piso);
                mv_cnt = 0;
                door_cnt = 0;
            end else begin
                if (int'(piso) != prev_piso) begin
                    if (step_q.size() == 0) begin
                        tfail("unexpected_step");
                    end else begin
                        e = step_q.pop_front();
                        chk("step_piso", int'(piso), e);
                        chk("step_ticks", mv_cnt, TT);
                    end
                    mv_cnt = (ocupado && !puertas_abiertas) ? 1 : 0;
                    prev_piso = int'(piso);
                end else if (ocupado && !puertas_abiertas) begin
                    mv_cnt++;
                end
                if (llegada) begin
                    if (arr_q.size() == 0) tfail("unexpected_llegada");
                    else begin
                        e = arr_q.pop_front();
                        chk("llegada_piso", int'(piso), e);
                    end
                end
                if (puertas_abiertas) begin
                    door_cnt++;
                end else if (door_cnt > 0) begin
                    if (dur_q.size() == 0) tfail("unexpected_door");
                    else begin
                        e = dur_q.pop_front();
                        chk("door_cycles", door_cnt, e);
                    end
                    door_cnt = 0;
                end
            end
        end
    end

    task automatic pulse(input logic [3:0] r);
        @(negedge clk);
        req_set = r;
        @(negedge clk);
        req_set = 4'b0000;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(ocupado == 1'b0 && pendientes == 4'b0000) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) tfail(name);
    endtask

    task automatic wait_piso(input int p, input string name);
        int n;
        n = 0;
        while (int'(piso) != p && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) tfail(name);
    endtask

    task automatic wait_llegada(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!llegada && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) tfail(name);
    endtask

    task automatic wait_doors_closed(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (puertas_abiertas && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) tfail(name);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_piso"}, int'(piso), 0);
        chk({tag, "_pendientes"}, int'(pendientes), 0);
        chk({tag, "_ocupado"}, int'(ocupado), 0);
        chk({tag, "_puertas"}, int'(puertas_abiertas), 0);
        chk({tag, "_direccion"}, int'(direccion), 0);
        chk({tag, "_llegada"}, int'(llegada), 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2 chk_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Straight run 0 -> 3
        step_q.push_back(1); step_q.push_back(2); step_q.push_back(3);
        arr_q.push_back(3); dur_q.push_back(DT);
        pulse(4'b1000);
        @(negedge clk);
        chk("t2_dir_up", int'(direccion), 1);
        wait_idle("t2_idle");
        chk("t2_piso", int'(piso), 3);
        chk("t2_pend", int'(pendientes), 0);

        // Down sweep with intermediate stop at 2
        step_q.push_back(2); step_q.push_back(1); step_q.push_back(0);
        arr_q.push_back(2); arr_q.push_back(0);
        dur_q.push_back(DT); dur_q.push_back(DT);
        pulse(4'b0101);
        @(negedge clk);
        chk("t3_dir_down", int'(direccion), 2);
        wait_idle("t3_idle");
        chk("t3_piso", int'(piso), 0);
        chk("t3_pend", int'(pendientes), 0);

        // Request behind the car: serve 3 first, then reverse to 1
        step_q.push_back(1); step_q.push_back(2); step_q.push_back(3);
        step_q.push_back(2); step_q.push_back(1);
        arr_q.push_back(3); arr_q.push_back(1);
        dur_q.push_back(DT); dur_q.push_back(DT);
        pulse(4'b1000);
        @(negedge clk);
        chk("t4_dir_up", int'(direccion), 1);
        wait_piso(2, "t4_reach2");
        req_set = 4'b0010;
        @(negedge clk);
        req_set = 4'b0000;
        wait_llegada("t4_arrive3");
        chk("t4_arrive_floor", int'(piso), 3);
        wait_doors_closed("t4_close3");
        chk("t4_dir_reversed", int'(direccion), 2);
        wait_idle("t4_idle");
        chk("t4_piso", int'(piso), 1);
        chk("t4_pend", int'(pendientes), 0);

        // Door re-open on third door cycle at floor 2
        step_q.push_back(2);
        arr_q.push_back(2);
        dur_q.push_back(3 + DT);
        pulse(4'b0100);
        wait_llegada("t5_arrive2");
        @(negedge clk);
        @(negedge clk);
        req_set = 4'b0100;
        @(negedge clk);
        req_set = 4'b0000;
        chk("t5_pend_not_latched", int'(pendientes), 0);
        wait_idle("t5_idle");
        chk("t5_piso", int'(piso), 2);

        // Return to 0, then reset in the middle of a move
        step_q.push_back(1); step_q.push_back(0);
        arr_q.push_back(0); dur_q.push_back(DT);
        pulse(4'b0001);
        wait_idle("t6_home");
        chk("t6_home_piso", int'(piso), 0);
        step_q.push_back(1);
        pulse(4'b1000);
        wait_piso(1, "t6_reach1");
        @(negedge clk);
        chk("t6_pend_before", int'(pendientes), 8);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("t6_async");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("t6_after_piso", int'(piso), 0);
        chk("t6_after_ocupado", int'(ocupado), 0);

        chk("step_q_left", step_q.size(), 0);
        chk("arr_q_left", arr_q.size(), 0);
        chk("dur_q_left", dur_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
